ov7670_capture: RTL and testbench
=================================

OV7670_CAPTURE -- requirements
Module: ov7670_capture

Interface
REQ-001 Parameter H_ACTIVE, default 640, pixels per line accepted.
REQ-002 Parameter V_ACTIVE, default 480, lines per frame accepted.
REQ-003 writeClk  in  1  camera pixel clock (PCLK); the only clock; all logic on rising edge.
REQ-004 resetN  in  1  reset; synchronous, active-low.
REQ-005 vsync  in  1  camera VSYNC, high = vertical blanking.
REQ-006 href  in  1  camera HREF, high = active line bytes on dataIn.
REQ-007 dataIn  in  8  camera byte bus, RGB444 mode: byte0 = {xxxx,R[3:0]}, byte1 = {G[3:0],B[3:0]}.
REQ-008 pixelOut  out  12  assembled pixel {R,G,B}; feeds the blur stage pixelIn.
REQ-009 pixelValid  out  1  one-cycle strobe, pixelOut/outX/outY valid.
REQ-010 outX  out  10  column of pixelOut, 0..H_ACTIVE-1.
REQ-011 outY  out  2  row of pixelOut modulo 4 (line-buffer row select).
REQ-012 lineCount  out  9  absolute row of pixelOut, 0..V_ACTIVE-1.
REQ-013 frameDone  out  1  one-cycle pulse at end of a captured frame.
REQ-014 lineErr  out  1  one-cycle pulse on malformed line.

Function
REQ-015 FSM states: INIT, VBLANK, LINE_WAIT, BYTE_HI, BYTE_LO.
REQ-016 INIT: discard all input until vsync=1, then VBLANK; guarantees no partial first frame.
REQ-017 VBLANK: hold x=0, row=0; on vsync=0 go LINE_WAIT.
REQ-018 LINE_WAIT with href=1: sample dataIn[3:0] as R, go BYTE_LO (this cycle is the BYTE_HI sample).
REQ-019 BYTE_HI with href=1: sample dataIn[3:0] as R, go BYTE_LO.
REQ-020 BYTE_LO with href=1: next cycle pixelOut={R,dataIn}, pixelValid=1, outX=x, outY=row[1:0], lineCount=row; x increments; go BYTE_HI.
REQ-021 Latency: pixelValid asserts exactly 1 cycle after the byte1 sampling edge; never two consecutive cycles.
REQ-022 Pixels with x >= H_ACTIVE or row >= V_ACTIVE: not emitted (pixelValid=0), x saturates at H_ACTIVE.
REQ-023 href 1->0 (any of BYTE_HI/BYTE_LO): x<=0, row<=row+1 (saturate at V_ACTIVE), go LINE_WAIT.
REQ-024 href falls in BYTE_LO (odd byte count): partial byte dropped, lineErr pulses next cycle.
REQ-025 href falls with x != H_ACTIVE (short or long line): lineErr pulses next cycle; row still advances.
REQ-026 vsync=1 in any non-INIT state: highest priority; abort line, x<=0, go VBLANK; frameDone pulses next cycle if row>0; row<=0.
REQ-027 outX/outY/lineCount/pixelOut hold last value when pixelValid=0.
REQ-028 outY is always lineCount[1:0].

Reset
REQ-029 resetN=0 at a writeClk edge: state<=INIT, x<=0, row<=0, R<=0.
REQ-030 Reset values: pixelOut=0, pixelValid=0, outX=0, outY=0, lineCount=0, frameDone=0, lineErr=0.
REQ-031 Reset mid-line or mid-pixel: partial pixel discarded, no strobe emitted, capture resumes only after next vsync high.

Structure
REQ-032 Shared package holds: FSM state enum, H_ACTIVE/V_ACTIVE defaults, pixel width 12, x width 10, row width 9.
REQ-033 One sub-module: ov7670_sync_edge (registers vsync/href, provides rise/fall pulses); everything else in ov7670_capture.

Verification
REQ-034 Reset, vsync 1->0, href high 4 cycles bytes 0x0A,0x5C,0x03,0xF1 -> pixelValid twice: 0xA5C @x=0,y=0 then 0x3F1 @x=1; no lineErr.
REQ-035 Full frame 640x480 random bytes -> 307200 strobes, outX wraps 639->0, outY cycles 0,1,2,3, lineCount ends 479, frameDone single pulse on vsync rise.
REQ-036 href low after 3 bytes -> one pixel emitted, lineErr pulse, next line outX restarts at 0 with lineCount=1.
REQ-037 Line of 642 pixels -> 640 strobes, pixels 640/641 dropped, lineErr pulse; 481st line -> no strobes.
REQ-038 Bytes driven before first vsync after reset -> no pixelValid; resetN low mid-line -> all outputs 0 next cycle, no capture until vsync cycle.
REQ-039 vsync high mid-line at x=100 -> line aborted, frameDone pulse, next frame starts at outX=0, lineCount=0.

Source files
------------

// File: rtl/ov7670_capture_pkg.sv
// Shared types and sizing for the OV7670 RGB444 capture block.
// Widths here bound the largest supported frame geometry.
package ov7670_capture_pkg;

    localparam int H_ACTIVE_DEF = 640;
    localparam int V_ACTIVE_DEF = 480;
    localparam int PIX_W        = 12;
    localparam int X_W          = 10;
    localparam int ROW_W        = 9;

    typedef enum logic [2:0] {
        ST_INIT      = 3'd0,
        ST_VBLANK    = 3'd1,
        ST_LINE_WAIT = 3'd2,
        ST_BYTE_HI   = 3'd3,
        ST_BYTE_LO   = 3'd4
    } cap_state_e;

endpackage

// File: rtl/ov7670_sync_edge.sv
// Registers the camera sync lines and derives the edge pulses the capture FSM needs.
// Pulses are combinational against the previous sample, so they align with the current byte.
module ov7670_sync_edge (
    input  logic clk_i,
    input  logic rst_n_i,
    input  logic vsync_i,
    input  logic href_i,
    output logic vsync_rise_o,
    output logic href_fall_o
);

    logic vsync_q;
    logic href_q;

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            vsync_q <= 1'b0;
            href_q  <= 1'b0;
        end else begin
            vsync_q <= vsync_i;
            href_q  <= href_i;
        end
    end

    assign vsync_rise_o = vsync_i & ~vsync_q;
    assign href_fall_o  = href_q & ~href_i;

endmodule

// File: rtl/ov7670_capture.sv
// OV7670 RGB444 byte-pair capture: assembles 12-bit pixels and tracks column/row.
// Valid/ready contract: pixelValid is a one-cycle strobe with no back-pressure; pixelOut/outX/outY/lineCount are qualified by it.
module ov7670_capture
    import ov7670_capture_pkg::*;
#(
    parameter int H_ACTIVE = H_ACTIVE_DEF,
    parameter int V_ACTIVE = V_ACTIVE_DEF
) (
    input  logic        writeClk,
    input  logic        resetN,
    input  logic        vsync,
    input  logic        href,
    input  logic [7:0]  dataIn,
    output logic [11:0] pixelOut,
    output logic        pixelValid,
    output logic [9:0]  outX,
    output logic [1:0]  outY,
    output logic [8:0]  lineCount,
    output logic        frameDone,
    output logic        lineErr,
    output logic [2:0]  stateDbg
);

    localparam logic [X_W-1:0]   X_MAX   = X_W'(H_ACTIVE);
    localparam logic [ROW_W-1:0] ROW_MAX = ROW_W'(V_ACTIVE);

    cap_state_e       state_q;
    logic [X_W-1:0]   x_q;
    logic [ROW_W-1:0] row_q;
    logic [3:0]       red_q;
    logic             ovf_q;
    logic [PIX_W-1:0] pixel_q;
    logic             valid_q;
    logic [X_W-1:0]   out_x_q;
    logic [ROW_W-1:0] line_q;
    logic             frame_done_q;
    logic             line_err_q;

    logic             vsync_rise;
    logic             href_fall;
    logic [ROW_W-1:0] row_d;
    logic             line_bad;

    ov7670_sync_edge u_sync_edge (
        .clk_i        (writeClk),
        .rst_n_i      (resetN),
        .vsync_i      (vsync),
        .href_i       (href),
        .vsync_rise_o (vsync_rise),
        .href_fall_o  (href_fall)
    );

    // x saturates, so a separate flag remembers that a line ran past H_ACTIVE.
    assign row_d    = (row_q < ROW_MAX) ? row_q + 9'd1 : row_q;
    assign line_bad = (x_q != X_MAX) | ovf_q;

    always_ff @(posedge writeClk) begin
        if (!resetN) begin
            state_q      <= ST_INIT;
            x_q          <= '0;
            row_q        <= '0;
            red_q        <= '0;
            ovf_q        <= 1'b0;
            pixel_q      <= '0;
            valid_q      <= 1'b0;
            out_x_q      <= '0;
            line_q       <= '0;
            frame_done_q <= 1'b0;
            line_err_q   <= 1'b0;
        end else begin
            valid_q      <= 1'b0;
            frame_done_q <= 1'b0;
            line_err_q   <= 1'b0;
            if (state_q != ST_INIT && vsync) begin
                x_q          <= '0;
                ovf_q        <= 1'b0;
                row_q        <= '0;
                frame_done_q <= (row_q != '0);
                state_q      <= ST_VBLANK;
            end else begin
                case (state_q)
                    ST_INIT: begin
                        if (vsync_rise) state_q <= ST_VBLANK;
                    end
                    ST_VBLANK: begin
                        x_q     <= '0;
                        row_q   <= '0;
                        ovf_q   <= 1'b0;
                        state_q <= ST_LINE_WAIT;
                    end
                    ST_LINE_WAIT: begin
                        if (href) begin
                            red_q   <= dataIn[3:0];
                            state_q <= ST_BYTE_LO;
                        end
                    end
                    ST_BYTE_HI: begin
                        if (href_fall) begin
                            line_err_q <= line_bad;
                            x_q        <= '0;
                            ovf_q      <= 1'b0;
                            row_q      <= row_d;
                            state_q    <= ST_LINE_WAIT;
                        end else begin
                            red_q   <= dataIn[3:0];
                            state_q <= ST_BYTE_LO;
                        end
                    end
                    ST_BYTE_LO: begin
                        if (href_fall) begin
                            line_err_q <= 1'b1;
                            x_q        <= '0;
                            ovf_q      <= 1'b0;
                            row_q      <= row_d;
                            state_q    <= ST_LINE_WAIT;
                        end else begin
                            if (x_q < X_MAX && row_q < ROW_MAX) begin
                                pixel_q <= {red_q, dataIn};
                                valid_q <= 1'b1;
                                out_x_q <= x_q;
                                line_q  <= row_q;
                            end
                            if (x_q < X_MAX) x_q <= x_q + 10'd1;
                            else             ovf_q <= 1'b1;
                            state_q <= ST_BYTE_HI;
                        end
                    end
                    default: state_q <= ST_INIT;
                endcase
            end
        end
    end

    assign pixelOut   = pixel_q;
    assign pixelValid = valid_q;
    assign outX       = out_x_q;
    assign outY       = line_q[1:0];
    assign lineCount  = line_q;
    assign frameDone  = frame_done_q;
    assign lineErr    = line_err_q;
    assign stateDbg   = state_q;

endmodule

// File: tb/tb_ov7670_capture.sv
// Scoreboard bench for ov7670_capture on a reduced 16x6 frame geometry.
// The driver pushes expected pixels as byte pairs are issued; a negedge monitor pops and compares.
module tb_ov7670_capture;

    localparam int H = 16;
    localparam int V = 6;

    logic        clk = 1'b0;
    logic        resetN = 1'b0;
    logic        vsync = 1'b0;
    logic        href = 1'b0;
    logic [7:0]  dataIn = 8'h00;
    logic [11:0] pixelOut;
    logic        pixelValid;
    logic [9:0]  outX;
    logic [1:0]  outY;
    logic [8:0]  lineCount;
    logic        frameDone;
    logic        lineErr;
    logic [2:0]  stateDbg;

    ov7670_capture #(.H_ACTIVE(H), .V_ACTIVE(V)) dut (
        .writeClk   (clk),
        .resetN     (resetN),
        .vsync      (vsync),
        .href       (href),
        .dataIn     (dataIn),
        .pixelOut   (pixelOut),
        .pixelValid (pixelValid),
        .outX       (outX),
        .outY       (outY),
        .lineCount  (lineCount),
        .frameDone  (frameDone),
        .lineErr    (lineErr),
        .stateDbg   (stateDbg)
    );

    always #5 clk = ~clk;

    // {pixel[11:0], x[9:0], row[8:0]}
    logic [30:0] exp_q[$];
    int vectors = 0, miscompares = 0;
    int err_cnt = 0, fd_cnt = 0, strobe_cnt = 0;
    int exp_err = 0, exp_fd = 0;
    int tb_x = 0, tb_row = 0, nb = 0;
    bit tb_ovf = 1'b0;
    bit prev_valid = 1'b0;
    logic [3:0] tb_r = 4'h0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        logic [30:0] e;
        if (frameDone) fd_cnt++;
        if (lineErr) err_cnt++;
        if (pixelValid) begin
            strobe_cnt++;
            check("strobe_gap", 32'(prev_valid), 32'd0);
            if (exp_q.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL unexpected_strobe: got pix=0x%0h x=%0d row=%0d expected no strobe",
                         pixelOut, outX, lineCount);
            end else begin
                e = exp_q.pop_front();
                check("pixelOut", 32'(pixelOut), 32'(e[30:19]));
                check("outX", 32'(outX), 32'(e[18:9]));
                check("lineCount", 32'(lineCount), 32'(e[8:0]));
                check("outY", 32'(outY), 32'(e[1:0]));
            end
        end
        prev_valid = pixelValid;
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic raw_byte(input logic [7:0] b);
        dataIn = b;
        href = 1'b1;
        tick();
    endtask

    task automatic model_byte(input logic [7:0] b);
        if (nb % 2 == 0) begin
            tb_r = b[3:0];
        end else begin
            if (tb_x < H && tb_row < V)
                exp_q.push_back({tb_r, b, 10'(tb_x), 9'(tb_row)});
            if (tb_x < H) tb_x++;
            else          tb_ovf = 1'b1;
        end
        nb++;
        raw_byte(b);
    endtask

    task automatic send_bytes(input int nbytes, input int seed);
        for (int i = 0; i < nbytes; i++)
            model_byte(8'((i * 29 + seed * 53 + 7) % 256));
    endtask

    task automatic send_line(input int nbytes, input int seed);
        send_bytes(nbytes, seed);
        href = 1'b0;
        tick();
        if ((nb % 2) != 0 || tb_x != H || tb_ovf) exp_err++;
        if (tb_row < V) tb_row++;
        tb_x = 0;
        tb_ovf = 1'b0;
        nb = 0;
        tick();
        tick();
    endtask

    task automatic frame_gap;
        vsync = 1'b1;
        href = 1'b0;
        tick();
        tick();
        tick();
        if (tb_row > 0) exp_fd++;
        tb_row = 0;
        tb_x = 0;
        tb_ovf = 1'b0;
        nb = 0;
        vsync = 1'b0;
        tick();
        tick();
    endtask

    task automatic check_point(input string tag);
        tick();
        check({tag, "_drain"}, 32'(exp_q.size()), 32'd0);
        check({tag, "_lineErr"}, 32'(err_cnt), 32'(exp_err));
        check({tag, "_frameDone"}, 32'(fd_cnt), 32'(exp_fd));
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_pixelValid"}, 32'(pixelValid), 32'd0);
        check({tag, "_pixelOut"}, 32'(pixelOut), 32'd0);
        check({tag, "_outX"}, 32'(outX), 32'd0);
        check({tag, "_outY"}, 32'(outY), 32'd0);
        check({tag, "_lineCount"}, 32'(lineCount), 32'd0);
        check({tag, "_frameDone"}, 32'(frameDone), 32'd0);
        check({tag, "_lineErr"}, 32'(lineErr), 32'd0);
        check({tag, "_state"}, 32'(stateDbg), 32'd0);
    endtask

    initial begin
        int s0;
        // Reset
        resetN = 1'b0;
        tick();
        tick();
        check_outputs_zero("reset");
        resetN = 1'b1;

        // Bytes before the first vsync must be ignored
        for (int i = 0; i < 8; i++) raw_byte(8'(8'h3C + i));
        href = 1'b0;
        tick();
        check_point("pre_vsync");

        // Two hand-computed pixels, then vsync aborts the line at row 0
        frame_gap();
        exp_q.push_back({12'hA5C, 10'd0, 9'd0});
        exp_q.push_back({12'h3F1, 10'd1, 9'd0});
        raw_byte(8'h0A);
        raw_byte(8'h5C);
        raw_byte(8'h03);
        raw_byte(8'hF1);
        frame_gap();
        check_point("two_pixels");

        // Full frame: x wraps, outY cycles, frameDone once on vsync
        s0 = strobe_cnt;
        for (int r = 0; r < V; r++) send_line(2 * H, r + 1);
        frame_gap();
        check_point("full_frame");
        check("full_frame_strobes", 32'(strobe_cnt - s0), 32'(H * V));

        // Odd-byte short line, normal line, long line, then past-last-row line
        send_line(3, 11);
        check_point("short_line");
        send_line(2 * H, 12);
        check_point("after_short");
        s0 = strobe_cnt;
        send_line(2 * H + 4, 13);
        check_point("long_line");
        check("long_line_strobes", 32'(strobe_cnt - s0), 32'(H));
        for (int r = 3; r < V; r++) send_line(2 * H, r + 20);
        s0 = strobe_cnt;
        send_line(2 * H, 30);
        check_point("extra_row");
        check("extra_row_strobes", 32'(strobe_cnt - s0), 32'd0);
        frame_gap();
        check_point("frame2_end");

        // vsync mid-line after row 0 completed
        send_line(2 * H, 40);
        send_bytes(20, 41);
        frame_gap();
        check_point("vsync_abort");
        send_line(2 * H, 42);
        check_point("after_abort");

        // Reset mid-pixel: outputs clear, nothing captured until vsync
        send_bytes(5, 50);
        resetN = 1'b0;
        dataIn = 8'h77;
        tick();
        check_outputs_zero("mid_reset");
        resetN = 1'b1;
        tb_row = 0;
        tb_x = 0;
        tb_ovf = 1'b0;
        nb = 0;
        for (int i = 0; i < 6; i++) raw_byte(8'(8'h90 + i));
        href = 1'b0;
        tick();
        check_point("post_reset_idle");
        frame_gap();
        send_line(2 * H, 60);
        check_point("post_reset_line");

        tick();
        tick();
        check("final_queue", 32'(exp_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
